// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizes for the program-RAM controller.
package ram_ctrl_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    PROG_IDLE,
    PROG_WRITE,
    PROG_CLEAR,
    RUN
  } state_t;
endpackage

// File: rtl/ram_prog_ctrl_if.sv
// Front panel, control-unit and RAM-port signals of the program-RAM controller.
interface ram_prog_ctrl_if;
  logic                               run_req;
  logic                               store_btn;
  logic                               step_btn;
  logic                               load_btn;
  logic                               clear_btn;
  logic [ram_ctrl_pkg::ADDR_W-1:0]    switch_addr;
  logic [ram_ctrl_pkg::DATA_W-1:0]    switch_dados;
  logic [ram_ctrl_pkg::ADDR_W-1:0]    uc_mar;
  logic                               uc_ram_in;
  logic                               uc_ram_out;
  logic                               prog_run;
  logic [ram_ctrl_pkg::ADDR_W-1:0]    ram_addr;
  logic                               ram_we;
  logic                               ram_re;
  logic [ram_ctrl_pkg::DATA_W-1:0]    ram_wdata;
  logic [ram_ctrl_pkg::ADDR_W-1:0]    ptr;
  logic                               busy;

  modport master (
    input  run_req, store_btn, step_btn, load_btn, clear_btn,
           switch_addr, switch_dados, uc_mar, uc_ram_in, uc_ram_out,
    output prog_run, ram_addr, ram_we, ram_re, ram_wdata, ptr, busy
  );

  modport slave (
    output run_req, store_btn, step_btn, load_btn, clear_btn,
           switch_addr, switch_dados, uc_mar, uc_ram_in, uc_ram_out,
    input  prog_run, ram_addr, ram_we, ram_re, ram_wdata, ptr, busy
  );
endinterface

// File: rtl/ram_prog_ctrl_btn_edge.sv
// Single-bit rising-edge detector; the history bit tracks the level every cycle.
module btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);
  logic prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;
endmodule

// File: rtl/ram_prog_ctrl.sv
// Program-RAM sequencer: panel-driven writes and clear in PROG mode,
// pass-through of the control unit's RAM port in RUN mode.
module ram_prog_ctrl
  import ram_ctrl_pkg::*;
(
  input logic             clock,
  input logic             reset,
  ram_prog_ctrl_if.master bus
);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                store_e, step_e, load_e, clear_e;

  btn_edge u_store (.clock(clock), .reset(reset), .level(bus.store_btn), .rise(store_e));
  btn_edge u_step  (.clock(clock), .reset(reset), .level(bus.step_btn),  .rise(step_e));
  btn_edge u_load  (.clock(clock), .reset(reset), .level(bus.load_btn),  .rise(load_e));
  btn_edge u_clear (.clock(clock), .reset(reset), .level(bus.clear_btn), .rise(clear_e));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PROG_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Edges arriving outside PROG_IDLE are simply not looked at, so they are lost.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      PROG_IDLE: begin
        if (clear_e) begin
          state_d = PROG_CLEAR;
          cnt_d   = '0;
        end else if (store_e) begin
          state_d = PROG_WRITE;
          data_d  = bus.switch_dados;
        end else if (load_e) begin
          ptr_d = bus.switch_addr;
        end else if (step_e) begin
          ptr_d = ptr_q + 1'b1;
        end else if (bus.run_req) begin
          state_d = RUN;
        end
      end
      PROG_WRITE: begin
        ptr_d   = ptr_q + 1'b1;
        state_d = PROG_IDLE;
      end
      PROG_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          ptr_d   = '0;
          state_d = PROG_IDLE;
        end
      end
      RUN: begin
        if (!bus.run_req) state_d = PROG_IDLE;
      end
      default: state_d = PROG_IDLE;
    endcase
  end

  always_comb begin
    bus.prog_run  = 1'b0;
    bus.ram_addr  = ptr_q;
    bus.ram_we    = 1'b0;
    bus.ram_re    = 1'b0;
    bus.ram_wdata = '0;
    bus.busy      = 1'b0;
    unique case (state_q)
      PROG_WRITE: begin
        bus.ram_we    = 1'b1;
        bus.ram_wdata = data_q;
        bus.busy      = 1'b1;
      end
      PROG_CLEAR: begin
        bus.ram_addr = cnt_q;
        bus.ram_we   = 1'b1;
        bus.busy     = 1'b1;
      end
      RUN: begin
        bus.prog_run = 1'b1;
        bus.ram_addr = bus.uc_mar;
        bus.ram_we   = bus.uc_ram_in;
        bus.ram_re   = bus.uc_ram_out;
      end
      default: ;
    endcase
  end

  assign bus.ptr = ptr_q;
endmodule

// File: tb/tb_ram_prog_ctrl.sv
// Bench for ram_prog_ctrl: directed scenarios with literal expectations, then
// randomized panel/UC activity compared every cycle against a behavioural model.
module tb_ram_prog_ctrl;
  import ram_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  ram_prog_ctrl_if bus ();

  ram_prog_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Model: remaining clear writes, a pending single write, run flag, pointer.
  int m_clr  = 0;
  bit m_wr   = 1'b0;
  bit m_run  = 1'b0;
  int m_ptr  = 0;
  int m_data = 0;
  bit p_sto = 0, p_stp = 0, p_lod = 0, p_clr = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin : model
    bit e_sto, e_stp, e_lod, e_clr;
    if (reset) begin
      m_clr = 0; m_wr = 0; m_run = 0; m_ptr = 0; m_data = 0;
      p_sto = 0; p_stp = 0; p_lod = 0; p_clr = 0;
    end else begin
      e_sto = bus.store_btn & ~p_sto;
      e_stp = bus.step_btn  & ~p_stp;
      e_lod = bus.load_btn  & ~p_lod;
      e_clr = bus.clear_btn & ~p_clr;
      if (m_clr > 0) begin
        m_clr--;
        if (m_clr == 0) m_ptr = 0;
      end else if (m_wr) begin
        m_wr  = 0;
        m_ptr = (m_ptr + 1) % DEPTH;
      end else if (m_run) begin
        m_run = bus.run_req;
      end else if (e_clr) begin
        m_clr = DEPTH;
      end else if (e_sto) begin
        m_wr   = 1;
        m_data = int'(bus.switch_dados);
      end else if (e_lod) begin
        m_ptr = int'(bus.switch_addr);
      end else if (e_stp) begin
        m_ptr = (m_ptr + 1) % DEPTH;
      end else if (bus.run_req) begin
        m_run = 1;
      end
      p_sto = bus.store_btn; p_stp = bus.step_btn;
      p_lod = bus.load_btn;  p_clr = bus.clear_btn;
    end
  end

  always @(negedge clock) begin : cmp
    int e_addr, e_we, e_re, e_wd, e_run, e_busy;
    if (armed) begin
      e_addr = m_ptr; e_we = 0; e_re = 0; e_wd = 0; e_run = 0; e_busy = 0;
      if (m_clr > 0) begin
        e_addr = DEPTH - m_clr; e_we = 1; e_busy = 1;
      end else if (m_wr) begin
        e_we = 1; e_wd = m_data; e_busy = 1;
      end else if (m_run) begin
        e_run  = 1;
        e_addr = int'(bus.uc_mar);
        e_we   = int'(bus.uc_ram_in);
        e_re   = int'(bus.uc_ram_out);
      end
      chk("m_prog_run", 32'(bus.prog_run), e_run);
      chk("m_ram_addr", 32'(bus.ram_addr), e_addr);
      chk("m_ram_we",   32'(bus.ram_we),   e_we);
      chk("m_ram_re",   32'(bus.ram_re),   e_re);
      chk("m_ram_wdata",32'(bus.ram_wdata),e_wd);
      chk("m_ptr",      32'(bus.ptr),      m_ptr);
      chk("m_busy",     32'(bus.busy),     e_busy);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_prog_run"}, 32'(bus.prog_run), 0);
    chk({tag, "_we"},       32'(bus.ram_we),   0);
    chk({tag, "_re"},       32'(bus.ram_re),   0);
    chk({tag, "_addr"},     32'(bus.ram_addr), 0);
    chk({tag, "_wdata"},    32'(bus.ram_wdata),0);
    chk({tag, "_ptr"},      32'(bus.ptr),      0);
    chk({tag, "_busy"},     32'(bus.busy),     0);
  endtask

  initial begin
    reset = 1'b1;
    bus.run_req = 0; bus.store_btn = 0; bus.step_btn = 0; bus.load_btn = 0;
    bus.clear_btn = 0; bus.switch_addr = '0; bus.switch_dados = '0;
    bus.uc_mar = '0; bus.uc_ram_in = 0; bus.uc_ram_out = 0;
    cyc();
    armed = 1'b1;
    cyc();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Store 0x3A at address 0
    bus.switch_dados = 8'h3A; bus.store_btn = 1;
    cyc();
    chk("st1_we", 32'(bus.ram_we), 1);
    chk("st1_addr", 32'(bus.ram_addr), 0);
    chk("st1_data", 32'(bus.ram_wdata), 'h3A);
    bus.store_btn = 0;
    cyc();
    chk("st1_ptr", 32'(bus.ptr), 1);
    chk("st1_we_off", 32'(bus.ram_we), 0);

    // Load 15, store 0x11, wrap, step
    bus.switch_addr = 4'hF; bus.load_btn = 1;
    cyc();
    bus.load_btn = 0;
    chk("ld_ptr", 32'(bus.ptr), 15);
    bus.switch_dados = 8'h11; bus.store_btn = 1;
    cyc();
    chk("st2_we", 32'(bus.ram_we), 1);
    chk("st2_addr", 32'(bus.ram_addr), 15);
    chk("st2_data", 32'(bus.ram_wdata), 'h11);
    bus.store_btn = 0;
    cyc();
    chk("st2_wrap", 32'(bus.ptr), 0);
    bus.step_btn = 1;
    cyc();
    bus.step_btn = 0;
    chk("step_ptr", 32'(bus.ptr), 1);

    // Clear with run_req held
    bus.run_req = 1; bus.clear_btn = 1;
    cyc();
    bus.clear_btn = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_we", 32'(bus.ram_we), 1);
      chk("clr_addr", 32'(bus.ram_addr), i);
      chk("clr_data", 32'(bus.ram_wdata), 0);
      chk("clr_busy", 32'(bus.busy), 1);
      cyc();
    end
    chk("clr_done_busy", 32'(bus.busy), 0);
    chk("clr_done_ptr", 32'(bus.ptr), 0);
    chk("clr_done_mode", 32'(bus.prog_run), 0);
    cyc();
    chk("run_entered", 32'(bus.prog_run), 1);

    // RUN pass-through; a store press writes nothing
    bus.uc_mar = 4'd7; bus.uc_ram_out = 1; bus.uc_ram_in = 0;
    #1;
    chk("run_addr", 32'(bus.ram_addr), 7);
    chk("run_re", 32'(bus.ram_re), 1);
    chk("run_we", 32'(bus.ram_we), 0);
    bus.store_btn = 1;
    cyc();
    chk("run_store_we", 32'(bus.ram_we), 0);
    bus.store_btn = 0;
    bus.run_req = 0; bus.uc_ram_out = 0;
    cyc();
    chk("run_exit", 32'(bus.prog_run), 0);
    chk("run_exit_ptr", 32'(bus.ptr), 0);

    // Store and step together: store wins, one increment
    bus.switch_dados = 8'h55; bus.store_btn = 1; bus.step_btn = 1;
    cyc();
    chk("both_we", 32'(bus.ram_we), 1);
    chk("both_data", 32'(bus.ram_wdata), 'h55);
    bus.store_btn = 0; bus.step_btn = 0;
    cyc();
    chk("both_ptr", 32'(bus.ptr), 1);

    // Reset during cycle 5 of a clear
    bus.clear_btn = 1;
    cyc();
    bus.clear_btn = 0;
    repeat (4) cyc();
    chk("clr5_addr", 32'(bus.ram_addr), 4);
    reset = 1;
    cyc();
    chk_reset_vals("rst_clr");
    reset = 0;

    // Randomized activity
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if ($urandom_range(0, 3) == 0)  bus.store_btn = ~bus.store_btn;
      if ($urandom_range(0, 3) == 0)  bus.step_btn  = ~bus.step_btn;
      if ($urandom_range(0, 4) == 0)  bus.load_btn  = ~bus.load_btn;
      if ($urandom_range(0, 29) == 0) bus.clear_btn = ~bus.clear_btn;
      if ($urandom_range(0, 19) == 0) bus.run_req   = ~bus.run_req;
      reset = ($urandom_range(0, 299) == 0);
      bus.switch_addr  = ADDR_W'($urandom);
      bus.switch_dados = DATA_W'($urandom);
      bus.uc_mar       = ADDR_W'($urandom);
      bus.uc_ram_in    = 1'($urandom);
      bus.uc_ram_out   = 1'($urandom);
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_prog_ctrl.md
# ram_prog_ctrl

Sequencer and owner of the 16x8 program RAM's control port. In PROG mode it turns front-panel buttons into single-cycle RAM writes with an auto-incrementing address pointer, and runs a hardware clear of all locations. In RUN mode it hands the RAM address and read/write strobes to the control unit. It sits between the front-panel switches/buttons, the control unit (UC) and the RAM, and generates the `prog_run` mode signal.

## Interface
- `ADDR_W`, 4, RAM address width; depth = 2**ADDR_W
- `DATA_W`, 8, RAM data width

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `run_req`  in  1  front-panel RUN switch, level
- `store_btn`  in  1  debounced level; rising edge = write switch data at pointer
- `step_btn`  in  1  debounced level; rising edge = pointer+1, no write
- `load_btn`  in  1  debounced level; rising edge = pointer <= `switch_addr`
- `clear_btn`  in  1  debounced level; rising edge = zero entire RAM
- `switch_addr`  in  ADDR_W  address switches
- `switch_dados`  in  DATA_W  data switches
- `uc_mar`  in  ADDR_W  MAR value from UC (RUN)
- `uc_ram_in`  in  1  UC write strobe (RUN)
- `uc_ram_out`  in  1  UC read strobe (RUN)
- `prog_run`  out  1  0 = PROG, 1 = RUN
- `ram_addr`  out  ADDR_W  RAM address
- `ram_we`  out  1  RAM write enable
- `ram_re`  out  1  RAM read enable (bus drive)
- `ram_wdata`  out  DATA_W  write data in PROG; 0 in RUN (RAM takes bus data)
- `ptr`  out  ADDR_W  current program pointer, for panel LEDs
- `busy`  out  1  high in PROG_WRITE and PROG_CLEAR

## Operation
- States: PROG_IDLE, PROG_WRITE, PROG_CLEAR, RUN.
- Rising edge detection: the previous-level register is updated every cycle in every state. An edge is `btn & ~prev`. Edges seen outside PROG_IDLE are discarded, not queued.
- PROG_IDLE, evaluated each cycle, highest priority first:
  - `clear` edge -> PROG_CLEAR, clear counter = 0.
  - `store` edge -> PROG_WRITE, latch `switch_dados`.
  - `load` edge -> pointer <= `switch_addr`, stay in PROG_IDLE.
  - `step` edge -> pointer+1, stay in PROG_IDLE.
  - Otherwise, if `run_req` = 1 -> RUN.
  - Lower-priority edges in the same cycle are dropped.
- PROG_WRITE (1 cycle):
  - `ram_addr` = pointer, `ram_wdata` = latched data, `ram_we` = 1.
  - Then pointer+1 and return to PROG_IDLE.
- PROG_CLEAR (2**ADDR_W cycles):
  - `ram_addr` = counter, `ram_wdata` = 0, `ram_we` = 1.
  - Counter increments each cycle.
  - After the write to the last address: pointer <= 0, return to PROG_IDLE.
  - `run_req` and all buttons are ignored until the clear completes.
- RUN:
  - `prog_run` = 1; `ram_addr` = `uc_mar`, `ram_we` = `uc_ram_in`, `ram_re` = `uc_ram_out`, `ram_wdata` = 0.
  - `run_req` = 0 -> PROG_IDLE next cycle. Pointer keeps its value from before RUN.
- PROG states: `ram_re` = 0, `prog_run` = 0. In PROG_IDLE, `ram_addr` = pointer and `ram_we` = 0.
- Pointer arithmetic is modulo 2**ADDR_W: 15+1 = 0 for both step and store.

## Timing
- Reset values:
  - state = PROG_IDLE, pointer = 0, clear counter = 0, data latch = 0, edge registers = 0.
  - Outputs: `prog_run` = 0, `ram_we` = 0, `ram_re` = 0, `ram_addr` = 0, `ram_wdata` = 0, `ptr` = 0, `busy` = 0.
- Reset asserted mid-WRITE or mid-CLEAR aborts the operation. `ram_we` is 0 from the first cycle after the reset edge.
- Store latency:
  - Button first sampled high at edge N.
  - `ram_we` high during cycle N..N+1; the RAM captures at edge N+1.
  - `ptr` shows the new value after edge N+1.
- Load and step: `ptr` updates at the edge after the button edge is detected.
- Clear: `busy` high for exactly 2**ADDR_W cycles, starting the cycle after the edge is sampled.
- Mode switch:
  - `prog_run` rises one cycle after `run_req` is sampled high in PROG_IDLE.
  - `prog_run` falls one cycle after `run_req` is sampled low in RUN.
- All outputs decode combinationally from registered state, pointer, counter and latch. In RUN they also follow the `uc_*` inputs combinationally. No other input-to-output paths.

## Structure
- Shared package `ram_ctrl_pkg`: state enum (PROG_IDLE, PROG_WRITE, PROG_CLEAR, RUN), and constants `ADDR_W`, `DATA_W`, `DEPTH`.
- Sub-module `btn_edge`: single-bit rising-edge detector with synchronous reset, instantiated once per button.
- Top level holds the FSM, pointer, clear counter, data latch and output muxing.

## Test plan
- After reset, set data switches to 0x3A and press store -> one-cycle `ram_we` with addr 0 and data 0x3A, then `ptr` = 1.
- Set address switches to 0xF and press load, then press store with data 0x11 -> write to address 15, then `ptr` wraps to 0. Press step once -> `ptr` = 1.
- Press clear with `run_req` = 1 held -> 16 consecutive writes of 0x00 to addresses 0..15, `busy` high for 16 cycles, then `ptr` = 0 and RUN entered on the following cycle.
- In RUN, drive `uc_mar` = 7, `uc_ram_out` = 1, `uc_ram_in` = 0 -> `ram_addr` = 7, `ram_re` = 1, `ram_we` = 0. A store press in RUN produces no write.
- Press store and step in the same cycle -> only the store occurs and `ptr` increments once. Assert `reset` during cycle 5 of a clear -> `ram_we` = 0 and all outputs at reset values on the next cycle.
